// File: rtl/operand_fetch_pkg.sv
// Shared constants and types for the operand fetch block: word and select widths,
// the register select encoding and the fetch sequencer states.
package operand_fetch_pkg;

    localparam int WORD_SIZE = 19;
    localparam int SEL_W     = 2;

    typedef logic [WORD_SIZE-1:0] word_t;

    typedef enum logic [SEL_W-1:0] {
        REG_A    = 2'd0,
        REG_B    = 2'd1,
        REG_C    = 2'd2,
        REG_NONE = 2'd3
    } reg_sel_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD1  = 3'd1,
        ST_RD2  = 3'd2,
        ST_CAP2 = 3'd3,
        ST_HOLD = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/operand_fetch_capture.sv
// One operand register with its write-forward latch; OPFETCH_BYPASS_EN enables forwarding
// of a same-cycle bank write, otherwise the bank read data is captured as-is.
module operand_capture
    import operand_fetch_pkg::*;
(
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             issue,
    input  logic [SEL_W-1:0] sel,
    input  logic             capture,
    input  logic             zero,
    input  word_t            rd_data,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  word_t            wr_data,
    output word_t            op
);

    word_t cap_data;

`ifdef OPFETCH_BYPASS_EN
    logic  fwd_valid;
    word_t fwd_data;
    logic  match;

    // The bank returns the pre-write value, so a write landing with the read must be forwarded.
    assign match = issue && wr_en && (wr_sel == sel) && (sel != REG_NONE);

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            fwd_valid <= 1'b0;
            fwd_data  <= '0;
        end else if (issue) begin
            fwd_valid <= match;
            if (match) fwd_data <= wr_data;
        end else if (capture) begin
            fwd_valid <= 1'b0;
        end
    end

    assign cap_data = fwd_valid ? fwd_data : rd_data;
`else
    logic unused_wr;
    assign unused_wr = ^{issue, sel, wr_en, wr_sel, wr_data};
    assign cap_data  = rd_data;
`endif

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            op <= '0;
        end else if (capture) begin
            op <= zero ? '0 : cap_data;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Read-side sequencer for the A-C register bank: fetches one or two operands through a single
// read port and presents them with a valid/ready handshake. Optional: OPFETCH_BYPASS_EN.
//
// state   | meaning
// IDLE    | ready for a decode request
// RD1     | read strobe for src1
// RD2     | capture op1, read strobe for src2 when two operands
// CAP2    | capture op2
// HOLD    | operands valid, waiting for the execute stage
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic                 clk_sys,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [SEL_W-1:0]     src1_sel,
    input  logic [SEL_W-1:0]     src2_sel,
    input  logic                 two_ops,
    output logic                 rd_en,
    output logic [SEL_W-1:0]     rd_sel,
    input  logic [WORD_SIZE-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [SEL_W-1:0]     wr_sel,
    input  logic [WORD_SIZE-1:0] wr_data,
    output logic [WORD_SIZE-1:0] op1,
    output logic [WORD_SIZE-1:0] op2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_err
);

    fetch_state_t state, state_nxt;
    reg_sel_t     src1_q, src2_q;
    logic         two_q;
    logic         err_q;

    always_ff @(posedge clk_sys) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid) state_nxt = ST_RD1;
            ST_RD1:  state_nxt = ST_RD2;
            ST_RD2:  state_nxt = two_q ? ST_CAP2 : ST_HOLD;
            ST_CAP2: state_nxt = ST_HOLD;
            ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rd_en     = 1'b0;
        rd_sel    = '0;
        out_valid = 1'b0;
        out_err   = 1'b0;
        case (state)
            ST_IDLE: req_ready = 1'b1;
            ST_RD1: begin
                if (src1_q != REG_NONE) begin
                    rd_en  = 1'b1;
                    rd_sel = src1_q;
                end
            end
            ST_RD2: begin
                if (two_q && (src2_q != REG_NONE)) begin
                    rd_en  = 1'b1;
                    rd_sel = src2_q;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                out_err   = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            src1_q <= REG_A;
            src2_q <= REG_A;
            two_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        src1_q <= reg_sel_t'(src1_sel);
                        src2_q <= reg_sel_t'(src2_sel);
                        two_q  <= two_ops;
                        err_q  <= 1'b0;
                    end
                end
                ST_RD1:  if (src1_q == REG_NONE) err_q <= 1'b1;
                ST_RD2:  if (two_q && (src2_q == REG_NONE)) err_q <= 1'b1;
                ST_HOLD: if (out_ready) err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    logic issue1, issue2, cap1, cap2, zero1, zero2;

    assign issue1 = rd_en && (state == ST_RD1);
    assign issue2 = rd_en && (state == ST_RD2);
    assign cap1   = (state == ST_RD2);
    assign cap2   = ((state == ST_RD2) && !two_q) || (state == ST_CAP2);
    assign zero1  = (src1_q == REG_NONE);
    // Single-operand requests load op2 with zero regardless of the latched src2.
    assign zero2  = !two_q || (src2_q == REG_NONE);

    operand_capture u_cap1 (
        .clk_sys (clk_sys),
        .rst     (rst),
        .issue   (issue1),
        .sel     (src1_q),
        .capture (cap1),
        .zero    (zero1),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .op      (op1)
    );

    operand_capture u_cap2 (
        .clk_sys (clk_sys),
        .rst     (rst),
        .issue   (issue2),
        .sel     (src2_q),
        .capture (cap2),
        .zero    (zero2),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .op      (op2)
    );

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register bank model, cycle-scripted driver filling a scoreboard
// queue, and a monitor that checks each operand handshake against it.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

`ifdef OPFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk_sys = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [SEL_W-1:0] src1_sel = '0;
    logic [SEL_W-1:0] src2_sel = '0;
    logic             two_ops = 1'b0;
    logic             rd_en;
    logic [SEL_W-1:0] rd_sel;
    word_t            rd_data = '0;
    logic             wr_en = 1'b0;
    logic [SEL_W-1:0] wr_sel = '0;
    word_t            wr_data = '0;
    word_t            op1, op2;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_err;

    always #5 clk_sys = ~clk_sys;

    operand_fetch dut (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .src1_sel  (src1_sel),
        .src2_sel  (src2_sel),
        .two_ops   (two_ops),
        .rd_en     (rd_en),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_err   (out_err)
    );

    // Register bank: read data one cycle after the strobe, pre-write value on a collision,
    // junk whenever no read was issued.
    word_t bank [3];
    always @(posedge clk_sys) begin
        if (rd_en && rd_sel != 2'd3) rd_data <= bank[rd_sel];
        else                         rd_data <= word_t'($urandom);
        if (wr_en && wr_sel != 2'd3) bank[wr_sel] <= wr_data;
    end

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        word_t op1;
        word_t op2;
        bit    err;
        int    lat;
        int    accept_cyc;
        int    n_rd;
    } exp_t;

    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic rand_wr();
        wr_en   = 1'($urandom);
        wr_sel  = 2'($urandom);
        wr_data = word_t'($urandom);
    endtask

    // Operand value expected for a read issued this cycle, given the write on the bus now.
    function automatic word_t model_op(input logic [1:0] s);
        if (s == 2'd3) return '0;
        if (BYP && wr_en && wr_sel == s) return wr_data;
        return bank[s];
    endfunction

    task automatic bank_write(input logic [1:0] s, input word_t d);
        wr_en = 1'b1; wr_sel = s; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_op1"}, 32'(op1), 32'd0);
        check({tag, "_op2"}, 32'(op2), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_err"}, 32'(out_err), 32'd0);
        check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        check({tag, "_rd_sel"}, 32'(rd_sel), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic do_req(input logic [1:0] s1, input logic [1:0] s2, input bit two,
                          input int hold, input bit quiet,
                          input bit fw, input logic [1:0] fw_sel, input word_t fw_data);
        exp_t e;
        src1_sel = s1; src2_sel = s2; two_ops = two; req_valid = 1'b1; out_ready = 1'b0;
        if (quiet) wr_en = 1'b0; else rand_wr();
        check("req_ready_idle", 32'(req_ready), 32'd1);
        e.accept_cyc = cyc;
        step();
        req_valid = 1'b0;
        src1_sel = 2'($urandom); src2_sel = 2'($urandom); two_ops = 1'($urandom);
        if (fw) begin
            wr_en = 1'b1; wr_sel = fw_sel; wr_data = fw_data;
        end else if (quiet) wr_en = 1'b0;
        else rand_wr();
        e.op1 = model_op(s1);
        step();
        if (quiet) wr_en = 1'b0; else rand_wr();
        e.op2  = two ? model_op(s2) : '0;
        e.err  = (s1 == 2'd3) || (two && s2 == 2'd3);
        e.lat  = two ? 4 : 3;
        e.n_rd = int'(s1 != 2'd3) + int'(two && s2 != 2'd3);
        exp_q.push_back(e);
        step();
        if (two) begin
            if (quiet) wr_en = 1'b0; else rand_wr();
            step();
        end
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            req_valid = 1'b1;
            src1_sel = 2'($urandom); src2_sel = 2'($urandom); two_ops = 1'($urandom);
            if (quiet) begin
                wr_en = 1'b1; wr_sel = 2'd0; wr_data = 19'h11111;
            end else rand_wr();
            check("req_ready_hold", 32'(req_ready), 32'd0);
            check("out_valid_hold", 32'(out_valid), 32'd1);
            step();
        end
        out_ready = 1'b1; req_valid = 1'b0; wr_en = 1'b0;
        check("out_valid_release", 32'(out_valid), 32'd1);
        step();
        out_ready = 1'b0;
        check("idle_after_release", 32'(req_ready), 32'd1);
    endtask

    // Monitor: pops an expectation on every operand handshake.
    int n_rd_seen = 0;
    int first_valid = 0;
    bit seen_valid = 1'b0;
    always @(negedge clk_sys) begin
        if (rst) begin
            n_rd_seen  = 0;
            seen_valid = 1'b0;
        end else begin
            if (rd_en) n_rd_seen++;
            else check("rd_sel_idle_zero", 32'(rd_sel), 32'd0);
            if (out_valid && !seen_valid) begin
                seen_valid  = 1'b1;
                first_valid = cyc;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_handshake", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("op1", 32'(op1), 32'(e.op1));
                    check("op2", 32'(op2), 32'(e.op2));
                    check("out_err", 32'(out_err), 32'(e.err));
                    check("latency", 32'(first_valid - e.accept_cyc), 32'(e.lat));
                    check("rd_en_pulses", 32'(n_rd_seen), 32'(e.n_rd));
                end
                n_rd_seen  = 0;
                seen_valid = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b1;
        step();
        step();
        check_reset_vals("reset");
        rst = 1'b0;

        // Two operands A and C
        bank_write(2'd0, 19'h00012);
        bank_write(2'd2, 19'h7FFFF);
        do_req(2'd0, 2'd2, 1'b1, 0, 1'b1, 1'b0, 2'd0, '0);
        // One operand B, src2 ignored
        bank_write(2'd1, 19'h3ABCD);
        do_req(2'd1, 2'd3, 1'b0, 0, 1'b1, 1'b0, 2'd0, '0);
        // Invalid src2, error then cleared by the next request
        do_req(2'd0, 2'd3, 1'b1, 1, 1'b1, 1'b0, 2'd0, '0);
        do_req(2'd2, 2'd0, 1'b1, 0, 1'b1, 1'b0, 2'd0, '0);
        // Invalid src1
        do_req(2'd3, 2'd1, 1'b1, 0, 1'b1, 1'b0, 2'd0, '0);
        // Backpressure with writes to A during hold
        bank_write(2'd0, 19'h00012);
        do_req(2'd0, 2'd2, 1'b1, 6, 1'b1, 1'b0, 2'd0, '0);

        // Reset while in CAP2
        bank_write(2'd0, 19'h00012);
        src1_sel = 2'd0; src2_sel = 2'd2; two_ops = 1'b1; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_vals("mid_reset");
        do_req(2'd1, 2'd0, 1'b1, 0, 1'b1, 1'b0, 2'd0, '0);

        // Same-cycle write to the register being read
        bank_write(2'd0, 19'h00012);
        do_req(2'd0, 2'd1, 1'b0, 0, 1'b1, 1'b1, 2'd0, 19'h05555);

        for (int i = 0; i < 200; i++) begin
            logic [1:0] s1, s2;
            s1 = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            s2 = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_req(s1, s2, 1'($urandom), $urandom_range(0, 3), 1'b0, 1'b0, 2'd0, '0);
        end

        step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
